gradient_descent_engine: RTL and testbench

Consumer stage behind the file-backed sample loader. Drives the loader's `init`/`next` strobes and reads one (X, Y) sample per step. Fits y = w·x + b by batch gradient descent over EPOCHS passes of the data set, then presents final w and b with a `done` pulse. All values are signed Q10.10 (20-bit, 10 fractional bits).

---
 rtl/gradient_descent_engine.sv | 175 +++++++++++++++++
 tb/tb_gradient_descent_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_descent_engine.sv
// gradient_descent_engine
//
// Fits y = w*x + b by batch gradient descent over EPOCHS passes of a data
// set streamed from a file-backed sample loader. Every value is signed
// Q10.10 (20 bits, FRAC fractional bits). Each epoch rewinds the loader
// (ld_init), accumulates sum(e) and sum(e*x) over all samples, then applies
//   w <- w - sum(e*x) * 2^-LR_SHIFT,   b <- b - sum(e) * 2^-LR_SHIFT
// where e = w*x + b - y. After the last epoch, done pulses for one cycle and
// w_out/b_out/epoch hold until the next start.
//
// Optional feature: define GD_SATURATE_EN to clamp updated w/b to the
// 20-bit signed range; otherwise they wrap (low 20 bits kept).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle training request, honoured only in IDLE
//   ld_init         loader rewind strobe (registered, one cycle per LOAD)
//   ld_next         loader advance strobe (registered, one cycle per NEXT)
//   ld_x, ld_y      current sample, signed Q10.10
//   ld_eof          loader end-of-file, valid the cycle after ld_next
//   busy            high from LOAD of the first epoch through last UPDATE
//   done            one-cycle pulse when training completes
//   w_out, b_out    current model parameters, signed Q10.10
//   epoch           completed epochs
//   sample_cnt      samples accumulated in the current epoch
module gradient_descent_engine #(
  parameter int                FRAC     = 10,
  parameter int                LR_SHIFT = 4,
  parameter int                EPOCHS   = 8,
  parameter int                ACC_W    = 48,
  parameter logic signed [19:0] W_INIT  = 20'sd0,
  parameter logic signed [19:0] B_INIT  = 20'sd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ld_init,
  output logic               ld_next,
  input  logic signed [19:0] ld_x,
  input  logic signed [19:0] ld_y,
  input  logic               ld_eof,
  output logic               busy,
  output logic               done,
  output logic signed [19:0] w_out,
  output logic signed [19:0] b_out,
  output logic [7:0]         epoch,
  output logic [15:0]        sample_cnt
);

  localparam int DATA_W = 20;
  localparam int PROD_W = 2 * DATA_W;      // w * x
  localparam int E_W    = 32;              // error term
  localparam int EX_W   = E_W + DATA_W;    // e * x
  localparam logic [7:0] LAST_EPOCH = 8'(EPOCHS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MAC, S_NEXT, S_CHECK, S_UPDATE, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic               r_ld_init, r_ld_next, r_busy, r_done;
  logic signed [DATA_W-1:0] r_w, r_b;
  logic [7:0]         r_epoch;
  logic [15:0]        r_cnt;
  logic signed [ACC_W-1:0]  r_sum_e, r_sum_ex;

  // Narrow an UPDATE result back to the 20-bit data format.
  function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [ACC_W:0] v);
`ifdef GD_SATURATE_EN
    if (v > (ACC_W+1)'(524287))
      return 20'sh7FFFF;
    else if (v < (ACC_W+1)'(-524288))
      return 20'sh80000;
    else
      return DATA_W'(v);
`else
    return DATA_W'(v);
`endif
  endfunction

  // Error and gradient terms for the sample currently on ld_x/ld_y.
  logic signed [PROD_W-1:0] w_prod;
  logic signed [E_W-1:0]    w_err;
  logic signed [EX_W-1:0]   w_ex;
  logic signed [ACC_W-1:0]  w_err_acc, w_ex_acc;

  assign w_prod    = PROD_W'(r_w) * PROD_W'(ld_x);
  assign w_err     = E_W'(w_prod >>> FRAC) + E_W'(r_b) - E_W'(ld_y);
  assign w_ex      = EX_W'(w_err) * EX_W'(ld_x);
  assign w_err_acc = ACC_W'(w_err);
  assign w_ex_acc  = ACC_W'(w_ex >>> FRAC);

  // Parameter update, one bit wider than the accumulators so the
  // subtraction itself cannot overflow before narrowing.
  logic signed [ACC_W:0] w_w_upd, w_b_upd;
  assign w_w_upd = (ACC_W+1)'(r_w) - (ACC_W+1)'(r_sum_ex >>> LR_SHIFT);
  assign w_b_upd = (ACC_W+1)'(r_b) - (ACC_W+1)'(r_sum_e >>> LR_SHIFT);

  logic w_last_epoch;
  assign w_last_epoch = (r_epoch == LAST_EPOCH);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_MAC;
      S_MAC:    w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = ld_eof ? S_UPDATE : S_MAC;
      S_UPDATE: w_state_nxt = w_last_epoch ? S_DONE : S_LOAD;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes and status are registered from the next state so each is
  // glitch-free and high exactly for the cycle spent in its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ld_init <= 1'b0;
      r_ld_next <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w       <= W_INIT;
      r_b       <= B_INIT;
      r_epoch   <= 8'd0;
      r_cnt     <= 16'd0;
      r_sum_e   <= '0;
      r_sum_ex  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ld_init <= (w_state_nxt == S_LOAD);
      r_ld_next <= (w_state_nxt == S_NEXT);
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done    <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w     <= W_INIT;
            r_b     <= B_INIT;
            r_epoch <= 8'd0;
          end
        end
        S_LOAD: begin
          r_sum_e  <= '0;
          r_sum_ex <= '0;
          r_cnt    <= 16'd0;
        end
        S_MAC: begin
          r_sum_e  <= r_sum_e + w_err_acc;
          r_sum_ex <= r_sum_ex + w_ex_acc;
          r_cnt    <= r_cnt + 16'd1;
        end
        S_UPDATE: begin
          r_w     <= sat_narrow(w_w_upd);
          r_b     <= sat_narrow(w_b_upd);
          r_epoch <= r_epoch + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign ld_init    = r_ld_init;
  assign ld_next    = r_ld_next;
  assign busy       = r_busy;
  assign done       = r_done;
  assign w_out      = r_w;
  assign b_out      = r_b;
  assign epoch      = r_epoch;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_gradient_descent_engine.sv
// Testbench for gradient_descent_engine. Three instances with different
// parameter sets share one clock/reset; each has its own loader model.
// Expected final w/b/epoch are computed by a reference model when a run is
// started, queued, and compared when the instance pulses done.
module tb_gradient_descent_engine;

  localparam int NI = 3;
  localparam int LR_A = 2, EP_A = 1;
  localparam int LR_B = 2, EP_B = 2;
  localparam int LR_C = 0, EP_C = 1;
  localparam int LR_T [NI] = '{LR_A, LR_B, LR_C};
  localparam int EP_T [NI] = '{EP_A, EP_B, EP_C};
  localparam int I0_T [NI] = '{0, 0, -524288};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start_s   [NI];
  logic               ld_init_w [NI];
  logic               ld_next_w [NI];
  logic               ld_eof_w  [NI];
  logic               busy_w    [NI];
  logic               done_w    [NI];
  logic signed [19:0] ld_x_w    [NI];
  logic signed [19:0] ld_y_w    [NI];
  logic signed [19:0] w_out_w   [NI];
  logic signed [19:0] b_out_w   [NI];
  logic [7:0]         epoch_w   [NI];
  logic [15:0]        cnt_w     [NI];

  gradient_descent_engine #(.FRAC(10), .LR_SHIFT(LR_A), .EPOCHS(EP_A), .ACC_W(48),
                            .W_INIT(20'sd0), .B_INIT(20'sd0)) u_a (
    .clk(clk), .rst(rst), .start(start_s[0]), .ld_init(ld_init_w[0]), .ld_next(ld_next_w[0]),
    .ld_x(ld_x_w[0]), .ld_y(ld_y_w[0]), .ld_eof(ld_eof_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .w_out(w_out_w[0]), .b_out(b_out_w[0]), .epoch(epoch_w[0]), .sample_cnt(cnt_w[0]));

  gradient_descent_engine #(.FRAC(10), .LR_SHIFT(LR_B), .EPOCHS(EP_B), .ACC_W(48),
                            .W_INIT(20'sd0), .B_INIT(20'sd0)) u_b (
    .clk(clk), .rst(rst), .start(start_s[1]), .ld_init(ld_init_w[1]), .ld_next(ld_next_w[1]),
    .ld_x(ld_x_w[1]), .ld_y(ld_y_w[1]), .ld_eof(ld_eof_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .w_out(w_out_w[1]), .b_out(b_out_w[1]), .epoch(epoch_w[1]), .sample_cnt(cnt_w[1]));

  gradient_descent_engine #(.FRAC(10), .LR_SHIFT(LR_C), .EPOCHS(EP_C), .ACC_W(48),
                            .W_INIT(20'sh80000), .B_INIT(20'sh80000)) u_c (
    .clk(clk), .rst(rst), .start(start_s[2]), .ld_init(ld_init_w[2]), .ld_next(ld_next_w[2]),
    .ld_x(ld_x_w[2]), .ld_y(ld_y_w[2]), .ld_eof(ld_eof_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .w_out(w_out_w[2]), .b_out(b_out_w[2]), .epoch(epoch_w[2]), .sample_cnt(cnt_w[2]));

  // Loader models: data changes on the edge that ends a strobe cycle.
  logic signed [19:0] mx [NI][8];
  logic signed [19:0] my [NI][8];
  int                 nsamp [NI];
  int                 lidx  [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ld_init_w[k]) begin
        lidx[k]     <= 0;
        ld_x_w[k]   <= mx[k][0];
        ld_y_w[k]   <= my[k][0];
        ld_eof_w[k] <= 1'b0;
      end else if (ld_next_w[k]) begin
        lidx[k] <= lidx[k] + 1;
        if (lidx[k] + 1 >= nsamp[k]) begin
          ld_eof_w[k] <= 1'b1;
        end else begin
          ld_x_w[k]   <= mx[k][lidx[k] + 1];
          ld_y_w[k]   <= my[k][lidx[k] + 1];
          ld_eof_w[k] <= 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint narrow20(input longint v);
`ifdef GD_SATURATE_EN
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
`else
    logic signed [19:0] t;
    t = v[19:0];
    return longint'(t);
`endif
  endfunction

  // Reference model of batch gradient descent on instance k's data set.
  function automatic void model(input int k, output longint wf, output longint bf);
    longint w, b, se, sex, x, y, e;
    w = I0_T[k];
    b = I0_T[k];
    for (int ep = 0; ep < EP_T[k]; ep++) begin
      se  = 0;
      sex = 0;
      for (int s = 0; s < nsamp[k]; s++) begin
        x = longint'(mx[k][s]);
        y = longint'(my[k][s]);
        e = ((w * x) >>> 10) + b - y;
        se  += e;
        sex += (e * x) >>> 10;
      end
      w = narrow20(w - (sex >>> LR_T[k]));
      b = narrow20(b - (se >>> LR_T[k]));
    end
    wf = w;
    bf = b;
  endfunction

  typedef struct {
    int     k;
    longint w;
    longint b;
    int     ep;
  } exp_t;
  exp_t sb_q [$];
  exp_t mon_e;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (done_w[k]) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected_done", k, -1);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sb_inst", k, mon_e.k);
          check_eq("sb_w_out", w_out_w[k], mon_e.w);
          check_eq("sb_b_out", b_out_w[k], mon_e.b);
          check_eq("sb_epoch", epoch_w[k], mon_e.ep);
        end
      end
    end
  end

  task automatic push_expected(input int k);
    longint wf, bf;
    model(k, wf, bf);
    sb_q.push_back('{k, wf, bf, EP_T[k]});
  endtask

  // Start a run on instance k and follow it to done, collecting protocol
  // counts. With hold=1, start stays high until after the DONE cycle.
  task automatic run(input int k, input bit hold, input int n_exp,
                     output int done_cyc, output int busy_cyc, output int n_init,
                     output int n_next, output int first_init);
    bit prev_eof, seen;
    push_expected(k);
    done_cyc = 0; busy_cyc = 0; n_init = 0; n_next = 0; first_init = 0;
    seen = 1'b0;
    prev_eof = ld_eof_w[k];
    @(posedge clk); #1 start_s[k] = 1'b1;
    @(posedge clk); #1 if (!hold) start_s[k] = 1'b0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      @(negedge clk);
      if (busy_w[k]) busy_cyc++;
      if (ld_init_w[k]) begin
        n_init++;
        if (first_init == 0) first_init = c;
      end
      if (ld_next_w[k]) n_next++;
      if (ld_init_w[k] && ld_next_w[k]) check_eq("strobe_overlap", 1, 0);
      if (ld_eof_w[k] && !prev_eof) check_eq("cnt_at_eof", cnt_w[k], n_exp);
      prev_eof = ld_eof_w[k];
      if (done_w[k]) begin
        seen = 1'b1;
        done_cyc = c;
      end
    end
    if (!seen) check_eq("done_timeout", 0, 1);
    @(posedge clk); #1;
    if (hold) start_s[k] = 1'b0;
    check_eq("done_one_cycle", done_w[k], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int dc, bc, ni, nn, fi, tmp;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      start_s[k] = 1'b0;
      nsamp[k]   = 1;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_busy", busy_w[0], 0);
    check_eq("rst_done", done_w[0], 0);
    check_eq("rst_ld_init", ld_init_w[0], 0);
    check_eq("rst_ld_next", ld_next_w[0], 0);
    check_eq("rst_w_a", w_out_w[0], 0);
    check_eq("rst_epoch", epoch_w[0], 0);
    check_eq("rst_cnt", cnt_w[0], 0);
    check_eq("rst_w_c", w_out_w[2], -524288);
    check_eq("rst_b_c", b_out_w[2], -524288);
    rst = 1'b0;
    @(negedge clk);

    // Single sample X=1.0, Y=2.0, LR_SHIFT=2
    mx[0][0] = 20'sh00400; my[0][0] = 20'sh00800; nsamp[0] = 1;
    run(0, 1'b0, 1, dc, bc, ni, nn, fi);
    check_eq("t1_done_cyc", dc, 6);
    check_eq("t1_busy_cyc", bc, 5);
    check_eq("t1_n_init", ni, 1);
    check_eq("t1_n_next", nn, 1);
    check_eq("t1_w_out", w_out_w[0], 512);
    check_eq("t1_b_out", b_out_w[0], 512);

    // Negative data X=-1.0, Y=1.0, LR_SHIFT=2
    mx[0][0] = 20'shFFC00; my[0][0] = 20'sh00400; nsamp[0] = 1;
    run(0, 1'b0, 1, dc, bc, ni, nn, fi);
    check_eq("neg_w_out", w_out_w[0], -256);
    check_eq("neg_b_out", b_out_w[0], 256);

    // Random multi-sample set
    nsamp[0] = 5;
    for (int s = 0; s < 5; s++) begin
      tmp = int'($urandom_range(0, 4095)) - 2048; mx[0][s] = tmp[19:0];
      tmp = int'($urandom_range(0, 8191)) - 4096; my[0][s] = tmp[19:0];
    end
    run(0, 1'b0, 5, dc, bc, ni, nn, fi);
    check_eq("rnd_done_cyc", dc, 1 + 3 * 5 + 1 + 1);

    // 3-sample file, two epochs
    mx[1][0] = 20'sh00400; my[1][0] = 20'sh00C00;
    mx[1][1] = 20'sh00800; my[1][1] = 20'sh01400;
    mx[1][2] = 20'shFFE00; my[1][2] = 20'sh00000;
    nsamp[1] = 3;
    run(1, 1'b0, 3, dc, bc, ni, nn, fi);
    check_eq("t2_busy_cyc", bc, 22);
    check_eq("t2_n_init", ni, 2);
    check_eq("t2_n_next", nn, 6);
    check_eq("t2_done_cyc", dc, 23);

    // Reset during the second MAC of a run
    push_expected(1);
    @(posedge clk); #1 start_s[1] = 1'b1;
    @(posedge clk); #1 start_s[1] = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_busy", busy_w[1], 1);
    check_eq("mid_cnt", cnt_w[1], 1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_busy", busy_w[1], 0);
    check_eq("abort_ld_init", ld_init_w[1], 0);
    check_eq("abort_ld_next", ld_next_w[1], 0);
    check_eq("abort_cnt", cnt_w[1], 0);
    check_eq("abort_epoch", epoch_w[1], 0);
    check_eq("abort_w_out", w_out_w[1], 0);
    check_eq("abort_b_out", b_out_w[1], 0);
    void'(sb_q.pop_back());
    @(negedge clk) rst = 1'b0;
    run(1, 1'b0, 3, dc, bc, ni, nn, fi);
    check_eq("rerun_first_init", fi, 1);
    check_eq("rerun_done_cyc", dc, 23);

    // start held high through busy and DONE
    run(1, 1'b1, 3, dc, bc, ni, nn, fi);
    check_eq("hold_n_init", ni, 2);
    check_eq("hold_done_cyc", dc, 23);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("hold_idle_init", ld_init_w[1], 0);
      check_eq("hold_idle_busy", busy_w[1], 0);
    end
    run(1, 1'b0, 3, dc, bc, ni, nn, fi);
    check_eq("after_hold_first_init", fi, 1);

    // Overflow: W_INIT=B_INIT=-512.0, X=1.0, Y=max, LR_SHIFT=0
    mx[2][0] = 20'sh00400; my[2][0] = 20'sh7FFFF; nsamp[2] = 1;
    run(2, 1'b0, 1, dc, bc, ni, nn, fi);
`ifdef GD_SATURATE_EN
    check_eq("ovf_w_out", w_out_w[2], 524287);
    check_eq("ovf_b_out", b_out_w[2], 524287);
`else
    check_eq("ovf_w_out", w_out_w[2], -1);
    check_eq("ovf_b_out", b_out_w[2], -1);
`endif

    repeat (2) @(negedge clk);
    check_eq("sb_left", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
